// File: rtl/alu_serial_seq_if.sv
// Issue-side handshake for the serial ALU sequencer.
// Issuer drives the request; sequencer returns status.
interface alu_serial_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             ready;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             illegal;
  logic             done;

  modport master (
    output start,
    output alu_ctl,
    output a_in,
    output b_in,
    input  ready,
    input  result,
    input  zero,
    input  overflow,
    input  illegal,
    input  done
  );

  modport slave (
    input  start,
    input  alu_ctl,
    input  a_in,
    input  b_in,
    output ready,
    output result,
    output zero,
    output overflow,
    output illegal,
    output done
  );
endinterface

// File: rtl/alu_serial_seq.sv
// Serial ALU sequencer: walks a 1-bit ALU slice LSB-first
// over WIDTH cycles, chaining carry and assembling the word.
module alu_serial_seq #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_serial_seq_if.slave bus,
  output logic            sl_a,
  output logic            sl_b,
  output logic            sl_sa,
  output logic            sl_sb,
  output logic            sl_cin,
  output logic            sl_sm,
  output logic [1:0]      sl_op,
  input  logic            sl_result,
  input  logic            sl_set,
  input  logic            sl_ovf
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] fin_word;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;

  logic [1:0]       op_q;
  logic             sa_q;
  logic             sb_q;
  logic             arith_q;
  logic             slt_q;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;
  logic             ill_q;

  logic [1:0]       d_op;
  logic             d_sa;
  logic             d_sb;
  logic             d_cin;
  logic             d_arith;
  logic             d_slt;
  logic             d_legal;

  assign last = (cnt == CW'(WIDTH - 1));

  // The slice result bit is the MSB of the word being shifted in.
  assign r_nxt = (r_sh >> 1)
               | {sl_result, {(WIDTH-1){1'b0}}};

  // SLT keeps only the overflow-corrected sign of the MSB.
  assign fin_word = slt_q
                  ? {{(WIDTH-1){1'b0}}, sl_set}
                  : r_nxt;

  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.overflow = ovf_q;
  assign bus.illegal  = ill_q;

  // Decode alu_ctl into slice controls and the initial carry.
  always_comb begin
    d_op    = 2'b00;
    d_sa    = 1'b0;
    d_sb    = 1'b0;
    d_cin   = 1'b0;
    d_arith = 1'b0;
    d_slt   = 1'b0;
    d_legal = 1'b1;
    unique case (1'b1)
      (bus.alu_ctl == 4'b0000): begin
        d_op = 2'b00;
      end
      (bus.alu_ctl == 4'b0001): begin
        d_op = 2'b01;
      end
      (bus.alu_ctl == 4'b0010): begin
        d_op    = 2'b10;
        d_arith = 1'b1;
      end
      (bus.alu_ctl == 4'b0110): begin
        d_op    = 2'b10;
        d_sb    = 1'b1;
        d_cin   = 1'b1;
        d_arith = 1'b1;
      end
      (bus.alu_ctl == 4'b0111): begin
        d_op  = 2'b11;
        d_sb  = 1'b1;
        d_cin = 1'b1;
        d_slt = 1'b1;
      end
      (bus.alu_ctl == 4'b1100): begin
        d_op = 2'b00;
        d_sa = 1'b1;
        d_sb = 1'b1;
      end
      default: begin
        d_legal = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state, handshake and slice drive; slice idles at 0.
  always_comb begin
    nxt      = state;
    bus.ready = 1'b0;
    bus.done  = 1'b0;
    sl_a     = 1'b0;
    sl_b     = 1'b0;
    sl_sa    = 1'b0;
    sl_sb    = 1'b0;
    sl_cin   = 1'b0;
    sl_sm    = 1'b0;
    sl_op    = 2'b00;
    unique case (state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          nxt = d_legal ? RUN : FIN;
        end
      end
      RUN: begin
        sl_a   = a_sh[0];
        sl_b   = b_sh[0];
        sl_sa  = sa_q;
        sl_sb  = sb_q;
        sl_cin = carry;
        sl_op  = op_q;
        if (last) begin
          nxt = FIN;
        end
      end
      FIN: begin
        bus.done = 1'b1;
        nxt      = IDLE;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Operand latch, bit-serial shift and carry chain.
  // Status is loaded on entry to FIN so it is valid with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh     <= '0;
      b_sh     <= '0;
      r_sh     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      op_q     <= 2'b00;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      arith_q  <= 1'b0;
      slt_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh    <= bus.a_in;
            b_sh    <= bus.b_in;
            r_sh    <= '0;
            cnt     <= '0;
            carry   <= d_cin;
            op_q    <= d_op;
            sa_q    <= d_sa;
            sb_q    <= d_sb;
            arith_q <= d_arith;
            slt_q   <= d_slt;
            if (!d_legal) begin
              result_q <= '0;
              zero_q   <= 1'b1;
              ovf_q    <= 1'b0;
              ill_q    <= 1'b1;
            end
          end
        end
        RUN: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          r_sh  <= r_nxt;
          carry <= carry ^ sl_ovf;
          cnt   <= cnt + 1'b1;
          if (last) begin
            result_q <= fin_word;
            zero_q   <= (fin_word == '0);
            ovf_q    <= arith_q & sl_ovf;
            ill_q    <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural
// 1-bit ALU slice closing the loop.
module tb_alu_serial_seq;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sl_a;
  logic       sl_b;
  logic       sl_sa;
  logic       sl_sb;
  logic       sl_cin;
  logic       sl_sm;
  logic [1:0] sl_op;
  logic       sl_result;
  logic       sl_set;
  logic       sl_ovf;
  logic       a2;
  logic       b2;
  logic       s;
  logic       co;

  int n_chk = 0;
  int n_pass = 0;

  alu_serial_seq_if #(.WIDTH(W)) bus ();

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .sl_a      (sl_a),
    .sl_b      (sl_b),
    .sl_sa     (sl_sa),
    .sl_sb     (sl_sb),
    .sl_cin    (sl_cin),
    .sl_sm     (sl_sm),
    .sl_op     (sl_op),
    .sl_result (sl_result),
    .sl_set    (sl_set),
    .sl_ovf    (sl_ovf)
  );

  always #5 clk = ~clk;

  // Reference 1-bit ALU slice.
  always_comb begin
    a2     = sl_a ^ sl_sa;
    b2     = sl_b ^ sl_sb;
    s      = a2 ^ b2 ^ sl_cin;
    co     = (a2 & b2) | (sl_cin & (a2 ^ b2));
    sl_ovf = sl_cin ^ co;
    sl_set = s ^ sl_ovf;
    case (sl_op)
      2'b00:   sl_result = a2 & b2;
      2'b01:   sl_result = a2 | b2;
      2'b10:   sl_result = s;
      default: sl_result = sl_sm;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic run_op(input logic [3:0] ctl,
                        input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input int poke,
                        output int lat);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.alu_ctl = ctl;
    bus.a_in    = a;
    bus.b_in    = b;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      bus.start   = (lat == poke);
      bus.alu_ctl = 4'b0000;
      bus.a_in    = ~a;
      bus.b_in    = b ^ 32'h5A5A_5A5A;
      if (lat == 5) chk("ready_run", W'(bus.ready), '0);
    end while (!bus.done && lat < 100);
    bus.start = 1'b0;
  endtask

  task automatic check_op(input string tag,
                          input logic [3:0] ctl,
                          input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic [W-1:0] exp_r,
                          input logic exp_z,
                          input logic exp_o,
                          input logic exp_i,
                          input int exp_lat,
                          input int poke);
    int lat;
    run_op(ctl, a, b, poke, lat);
    chk({tag, ".lat"}, W'(lat), W'(exp_lat));
    chk({tag, ".result"}, bus.result, exp_r);
    chk({tag, ".zero"}, W'(bus.zero), W'(exp_z));
    chk({tag, ".ovf"}, W'(bus.overflow), W'(exp_o));
    chk({tag, ".ill"}, W'(bus.illegal), W'(exp_i));
    @(posedge clk);
    #1;
    chk({tag, ".pulse"}, W'(bus.done), '0);
    chk({tag, ".ready"}, W'(bus.ready), W'(1'b1));
  endtask

  initial begin
    int ndone;
    bus.start   = 1'b0;
    bus.alu_ctl = 4'b0000;
    bus.a_in    = '0;
    bus.b_in    = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", W'(bus.ready), W'(1'b1));
    chk("rst.done", W'(bus.done), '0);
    chk("rst.result", bus.result, '0);
    chk("rst.zero", W'(bus.zero), '0);
    chk("rst.ovf", W'(bus.overflow), '0);
    chk("rst.ill", W'(bus.illegal), '0);
    chk("rst.slice",
        W'({sl_a, sl_b, sl_sa, sl_sb, sl_cin, sl_sm, sl_op}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    check_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001,
             32'h8000_0000, 1'b0, 1'b1, 1'b0, 33, 0);
    check_op("sub_zero", 4'b0110, 32'h0000_0005, 32'h0000_0005,
             32'h0000_0000, 1'b1, 1'b0, 1'b0, 33, 0);
    check_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001,
             32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 33, 0);
    check_op("illegal", 4'b0101, 32'h1234_5678, 32'h0000_0001,
             32'h0000_0000, 1'b1, 1'b0, 1'b1, 1, 0);
    check_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h0000_0001,
             32'h0000_0001, 1'b0, 1'b0, 1'b0, 33, 0);
    check_op("slt_pos", 4'b0111, 32'h0000_0001, 32'hFFFF_FFFF,
             32'h0000_0000, 1'b1, 1'b0, 1'b0, 33, 0);
    check_op("slt_min", 4'b0111, 32'h8000_0000, 32'h7FFF_FFFF,
             32'h0000_0001, 1'b0, 1'b0, 1'b0, 33, 0);
    check_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00,
             32'hF000_F000, 1'b0, 1'b0, 1'b0, 33, 0);
    check_op("or", 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00,
             32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 33, 0);
    check_op("nor", 4'b1100, 32'h0000_0000, 32'h0000_0000,
             32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33, 0);
    check_op("add_mix", 4'b0010, 32'h1234_5678, 32'h9ABC_DEF0,
             32'hACF1_3568, 1'b0, 1'b0, 1'b0, 33, 0);

    check_op("poke", 4'b0010, 32'h0000_0001, 32'h0000_0002,
             32'h0000_0003, 1'b0, 1'b0, 1'b0, 33, 6);
    ndone = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("poke.no_queue", W'(ndone), '0);

    @(negedge clk);
    bus.start   = 1'b1;
    bus.alu_ctl = 4'b0110;
    bus.a_in    = 32'h0000_0009;
    bus.b_in    = 32'h0000_0004;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort.sub_ctl",
        W'({sl_op, sl_sa, sl_sb, sl_sm}), W'(5'b10010));
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.result", bus.result, '0);
    chk("abort.ready", W'(bus.ready), W'(1'b1));
    chk("abort.done", W'(bus.done), '0);
    chk("abort.slice",
        W'({sl_a, sl_b, sl_sa, sl_sb, sl_cin, sl_sm, sl_op}), '0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("abort.no_done", W'(ndone), '0);

    check_op("fresh", 4'b0010, 32'h0000_0002, 32'h0000_0003,
             32'h0000_0005, 1'b0, 1'b0, 1'b0, 33, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
